// File: rtl/reg_trace_monitor_if.sv
// ---------------------------------------------------------------------------
// reg_trace_monitor_if
// Record stream carrying trace records out of reg_trace_monitor.
// Signals:
//   rec_valid  head record available (producer -> consumer)
//   rec_ready  consumer accepts head record (consumer -> producer)
//   rec_cycle  cycle stamp of head record
//   rec_idx    register number of head record, 1..10
//   rec_value  register value of head record
// Modports: master = record producer (the monitor), slave = record consumer.
// ---------------------------------------------------------------------------
interface reg_trace_monitor_if;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_cycle;
    logic [3:0]  rec_idx;
    logic [31:0] rec_value;

    modport master (
        output rec_valid,
        output rec_cycle,
        output rec_idx,
        output rec_value,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_cycle,
        input  rec_idx,
        input  rec_value,
        output rec_ready
    );
endinterface

// File: rtl/reg_trace_monitor.sv
// ---------------------------------------------------------------------------
// reg_trace_monitor
// Watches ten 32-bit CPU register taps and emits one time-stamped record
// {cycle, register number, value} per observed change through a show-ahead
// record FIFO. A register that changes again while its previous change is
// still waiting to be queued is coalesced: the latest value wins and the
// sticky overflow flag is raised.
//
// Parameters:
//   DEPTH      record FIFO entries (power of two, 4..64)
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   taps       10 x 32-bit taps, tap i = taps[32*i+31:32*i] = reg(i+1)
//   rec        record stream (master modport of reg_trace_monitor_if)
//   overflow   sticky: at least one change was coalesced
//   drop_cnt   16-bit saturating coalesced-change count
//              (only when RTM_DROP_CNT_EN is defined)
// Build option:
//   RTM_DROP_CNT_EN  adds the drop_cnt port and its counter.
// ---------------------------------------------------------------------------
module reg_trace_monitor #(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [319:0]         taps,
    reg_trace_monitor_if.master  rec,
    output logic                 overflow
`ifdef RTM_DROP_CNT_EN
    ,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int NREG = 10;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int RW   = 32 + 4 + 32;

    // Global state
    logic [31:0]   cnt_reg;
    logic          prime_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;

    // Record storage: written by the issuer, head read asynchronously so the
    // FIFO can present its head in the same cycle it becomes non-empty.
    logic [RW-1:0] mem [DEPTH];

    // Per-register views gathered from the generate block
    logic [NREG-1:0] pend_vec;
    logic [NREG-1:0] drop_vec;
    logic [31:0]     stamp_arr [NREG];
    logic [31:0]     val_arr   [NREG];

    logic [3:0]    issue_idx;
    logic          issue_en;
    logic [RW-1:0] push_data;
    logic [RW-1:0] head;
    logic          show_valid;
    logic          pop;

    // Lowest-index pending register wins the issue slot.
    always_comb begin
        issue_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (pend_vec[i]) begin
                issue_idx = 4'(i);
            end
        end
    end

    // Occupancy is taken at the start of the cycle, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign issue_en  = (pend_vec != '0) && (count_reg < CW'(DEPTH));
    assign push_data = {stamp_arr[issue_idx], issue_idx + 4'd1, val_arr[issue_idx]};

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_tap
            logic [31:0] tap_val;
            logic [31:0] prev_reg;
            logic        pend_reg;
            logic [31:0] stamp_reg;
            logic [31:0] val_reg;
            logic        change;
            logic        hit;

            assign tap_val = taps[32*gi +: 32];
            // The first cycle after reset only primes prev_reg.
            assign change  = !prime_reg && (tap_val != prev_reg);
            assign hit     = issue_en && (issue_idx == 4'(gi));
            // A change that lands on the register being issued this cycle
            // is simply re-armed, not a coalesce.
            assign drop_vec[gi]  = change && pend_reg && !hit;
            assign pend_vec[gi]  = pend_reg;
            assign stamp_arr[gi] = stamp_reg;
            assign val_arr[gi]   = val_reg;

            always_ff @(posedge clk) begin
                prev_reg <= tap_val;
                if (reset) begin
                    pend_reg  <= 1'b0;
                    stamp_reg <= '0;
                    val_reg   <= '0;
                end else if (change) begin
                    // Set wins over the issue clear; the issued record has
                    // already taken the old stamp/value.
                    pend_reg  <= 1'b1;
                    stamp_reg <= cnt_reg;
                    val_reg   <= tap_val;
                end else if (hit) begin
                    pend_reg  <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (issue_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= '0;
            prime_reg    <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_reg + 32'd1;
            prime_reg <= 1'b0;
            if (issue_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({issue_en, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop_vec != '0) begin
                overflow_reg <= 1'b1;
            end
        end
    end

`ifdef RTM_DROP_CNT_EN
    // Several registers may coalesce in the same cycle; each one counts.
    logic [15:0] drop_reg;
    logic [3:0]  drop_num;
    logic [16:0] drop_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NREG; i++) begin
            drop_num = drop_num + 4'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_reg} + 17'(drop_num);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_reg <= '0;
        end else begin
            drop_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign drop_cnt = reset ? 16'h0000 : drop_reg;
`endif

    // Outputs read as zero while empty or while reset is held.
    assign head       = mem[rd_ptr_reg];
    assign show_valid = (count_reg != '0) && !reset;
    assign pop        = show_valid && rec.rec_ready;

    assign rec.rec_valid = show_valid;
    assign rec.rec_cycle = show_valid ? head[67:36] : 32'h0;
    assign rec.rec_idx   = show_valid ? head[35:32] : 4'h0;
    assign rec.rec_value = show_valid ? head[31:0]  : 32'h0;
    assign overflow      = overflow_reg && !reset;

endmodule

// File: doc/reg_trace_monitor.md
REG_TRACE_MONITOR -- requirements
Module: reg_trace_monitor

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set record FIFO entry count (power of two, 4..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 taps  input  320  CPU register taps from System_topEntity; tap i (0..9) = taps[32*i+31:32*i] = reg(i+1).
REQ-005 rec_valid  output  1  head record available.
REQ-006 rec_ready  input  1  consumer accepts head record.
REQ-007 rec_cycle  output  32  cycle stamp of head record.
REQ-008 rec_idx  output  4  register number of head record, 1..10.
REQ-009 rec_value  output  32  register value of head record.
REQ-010 overflow  output  1  sticky: at least one change coalesced while pending.
REQ-011 drop_cnt  output  16  coalesced-change count (present only with RTM_DROP_CNT_EN).

Function
REQ-012 Free-running cycle counter cnt SHALL be 0 in the first cycle after reset release, +1 per cycle, wrap 0xFFFFFFFF->0.
REQ-013 prev[i] SHALL capture tap i every cycle; first cycle after reset: prime only, no change events.
REQ-014 Change on tap i: taps value != prev[i] in a non-prime cycle.
REQ-015 On change i: pend[i] set, stamp[i]<=cnt, val[i]<=tap i.
REQ-016 Change on i while pend[i] already set and not issued that cycle: stamp/val overwritten (latest wins), overflow set, drop_cnt +1 saturating at 0xFFFF.
REQ-017 Issuer: if pend!=0 and FIFO not full, push one record {stamp, idx, val} for lowest-index pending register per cycle; clear its pend bit.
REQ-018 Same-cycle issue and new change on same i: issued record carries old stamp/val; pend[i] stays set with new stamp/val; no drop counted.
REQ-019 Full FIFO: no push; pend bits held; no bypass of a same-cycle pop (push only when count<DEPTH at cycle start).
REQ-020 FIFO: show-ahead; rec_valid=(count!=0); rec_* reflect head; pop when rec_valid&rec_ready.
REQ-021 rec_* SHALL stay stable while rec_valid=1 and rec_ready=0.
REQ-022 Latency: isolated change in cycle N (FIFO empty, no other pend) -> rec_valid=1 in cycle N+2 with rec_cycle=N.
REQ-023 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-024 Records SHALL leave in push order; none lost except via coalescing (REQ-016).

Reset
REQ-025 reset SHALL clear cnt, pend, count, pointers, overflow, drop_cnt; force prime state.
REQ-026 During/immediately after reset: rec_valid=0, rec_cycle=0, rec_idx=0, rec_value=0, overflow=0, drop_cnt=0.
REQ-027 Reset mid-operation SHALL discard all queued and pending records in that cycle.

Configuration
REQ-028 Macro RTM_DROP_CNT_EN defined: drop_cnt port and 16-bit saturating counter present.
REQ-029 RTM_DROP_CNT_EN undefined: drop_cnt port and counter absent; overflow behaviour unchanged.

Verification
REQ-030 Reset, then tap 3 changes 0->0x0000002A in cycle 5, rec_ready=1 -> one record {5, 3, 0x2A} visible in cycle 7, then rec_valid=0.
REQ-031 Taps 1, 4, 10 change in cycle 8 -> records idx 1, 4, 10 in consecutive cycles, all rec_cycle=8.
REQ-032 rec_ready=0; tap 2 changes every cycle for DEPTH+3 cycles -> DEPTH records queued, overflow=1, drop_cnt=2 (last value retained in pend).
REQ-033 Tap 5 toggles 0/1 with cnt near 0xFFFFFFFE (cnt preloaded via long run or force) -> stamps 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 in order.
REQ-034 Assert reset with 6 records queued -> next cycle rec_valid=0, overflow=0; taps unchanged after release -> no records.
REQ-035 Build without RTM_DROP_CNT_EN, repeat REQ-032 -> overflow=1, identical record stream, no drop_cnt port.
